pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Multi-channel programmable pulse-train generator, the synthesizable, parametrised successor to the free-running pulse and one-shot trigger models used in the timing guides. Each channel produces a burst of N pulses, or a continuous train, with a programmed high time and low time in clock cycles. Channels start on a rising edge of their `on` input and raise a one-cycle `done` when they finish. The block sits between the testbench/control logic that owns `on` and any downstream logic that needs gated timing strobes.

## Interface
- `CHANNELS`, default 4: number of independent channels (≥1).
- `WIDTH`, default 8: width of the high-time and low-time counters.
- `NPW`, default 4: width of the pulse-count field.
- `CHW`, default 2: width of `cfg_ch`; must be ≥ clog2(CHANNELS).

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `on` in CHANNELS: per-channel trigger/enable level inputs.
- `cfg_we` in 1: configuration write strobe.
- `cfg_ch` in CHW: channel index for the write.
- `cfg_high` in WIDTH: high time in cycles (0 is treated as 1).
- `cfg_low` in WIDTH: low time in cycles (0 is treated as 1).
- `cfg_count` in NPW: pulses per burst in mode 0 (0 is treated as 1).
- `cfg_mode` in 1: 0 = counted burst, 1 = continuous while `on` is high.
- `signal` out CHANNELS: pulse outputs, registered.
- `busy` out CHANNELS: channel is not IDLE, registered.
- `done` out CHANNELS: one-cycle end-of-run strobe, registered.

## Operation
- **Reset** (`reset_n`=0, asynchronous):
  - `signal`, `busy`, `done` and the `on` history register go to 0.
  - All channels go to IDLE.
  - Config registers go to high=1, low=1, count=1, mode=0.
- **Config write:** when `cfg_we`=1 at a clock edge, the channel selected by `cfg_ch` stores high, low, count and mode.
  - A `cfg_ch` value ≥ CHANNELS is ignored.
  - Writes are allowed while a channel is busy. They affect only the next run, because a run uses a working copy latched at start.
- **Trigger:** a rising edge on channel i is `on[i]`=1 sampled at an edge where the previous sample was 0.
  - A rising edge sampled while the channel is not IDLE is ignored and not queued.
- **Per-channel state machine:** states IDLE, HIGH, LOW.
  - IDLE → HIGH on a trigger. At that edge: latch config, load the phase counter with H-1, load the remaining-pulse counter with N-1, and set `signal`=1.
  - HIGH, counter >0 → decrement.
  - HIGH, counter =0, mode 0, remaining >0 → LOW. Set `signal`=0, counter=L-1, decrement remaining.
  - HIGH, counter =0, mode 0, remaining =0 → IDLE. Set `signal`=0 and `done`=1.
  - HIGH, counter =0, mode 1 → LOW if `on[i]` is sampled 1 at that edge. Otherwise → IDLE with `signal`=0 and `done`=1.
  - LOW, counter >0 → decrement.
  - LOW, counter =0 → HIGH. Set `signal`=1 and counter=H-1.
- **Run boundaries:**
  - A run always ends after a HIGH phase; there is no trailing LOW phase.
  - In mode 1, the run starts on a rising edge of `on[i]`. Dropping `on[i]` during LOW does not cut the phase short.
  - Mode 1 ignores `cfg_count`.
- **Independence:** channels are fully independent. Simultaneous triggers, writes to other channels, and a write to the running channel in the same cycle do not interact.

## Timing
- **Start latency:** `signal[i]` and `busy[i]` rise at the same edge that first samples `on[i]`=1. Effectively one cycle after `on` changes, if `on` is driven between edges.
- **Phase lengths:** `signal` is high for exactly max(H,1) cycles and low for max(L,1) cycles per pulse.
  - Mode 0 busy duration: N·H + (N-1)·L cycles.
- **End of run:** `done[i]` is 1 for exactly one cycle, at the edge where the final HIGH ends (`signal` falls and `busy` falls at that same edge).
- **Back-to-back runs:** a trigger can start a new run no earlier than the cycle after `done`. This requires `on[i]` to be sampled 0 at least once, then 1.
- **Reset mid-run:** outputs clear immediately, without waiting for a clock edge. No `done` is produced. After release, a fresh rising edge is required.

## Test plan
- **Reset mid-run:**
  - Stimulus: assert `reset_n`=0 during a HIGH phase.
  - Response: `signal`/`busy`/`done` go to 0 before the next edge, and config reads back as defaults. After release, with `on` held at 1, no run starts until `on` goes 0 then 1.
- **Counted burst:**
  - Stimulus: ch0 configured H=3, L=2, N=3, mode 0; raise `on[0]`.
  - Response: `signal[0]` = 1,1,1,0,0,1,1,1,0,0,1,1,1, then 0. `busy[0]` is high 13 cycles. `done[0]` is 1 only in cycle 14.
- **Zero fields:**
  - Stimulus: ch1 configured H=0, L=0, N=0; raise `on[1]`.
  - Response: a single 1-cycle pulse, and `done[1]` in the next cycle.
- **Continuous mode:**
  - Stimulus: ch2 configured H=2, L=1, mode 1; hold `on[2]` high for 7 cycles from the start.
  - Response: `signal[2]` = 1,1,0,1,1,0,1,1, then 0 with `done[2]`. The run ends at the first HIGH end that samples `on`=0.
- **Retrigger and live config:**
  - Stimulus: during a ch3 burst, toggle `on[3]` and write ch3 H=5.
  - Response: the current burst is unchanged, with no extra pulses. The next run uses H=5.
- **Concurrency and invalid channel:**
  - Stimulus: with CHANNELS=3, CHW=2, trigger ch0 and ch2 in the same cycle with different configs, and write `cfg_ch`=3.
  - Response: both channels follow their own timing exactly, and the write to `cfg_ch`=3 has no effect.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse-train generator: counted bursts or continuous trains with
// programmable high/low times; each channel runs from a config copy latched at start.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a rising edge on on[i]
// ST_HIGH | signal high, phase counter counting H-1 .. 0
// ST_LOW  | signal low between pulses, phase counter counting L-1 .. 0
module pulse_train_gen #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int NPW      = 4,
    parameter int CHW      = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] on,
    input  logic                cfg_we,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [WIDTH-1:0]    cfg_high,
    input  logic [WIDTH-1:0]    cfg_low,
    input  logic [NPW-1:0]      cfg_count,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] signal,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t              r_state    [CHANNELS];
    state_t              w_state_nx [CHANNELS];
    logic [WIDTH-1:0]    r_cnt      [CHANNELS];
    logic [WIDTH-1:0]    w_cnt_nx   [CHANNELS];
    logic [NPW-1:0]      r_rem      [CHANNELS];
    logic [NPW-1:0]      w_rem_nx   [CHANNELS];
    logic [WIDTH-1:0]    r_cfg_high [CHANNELS];
    logic [WIDTH-1:0]    r_cfg_low  [CHANNELS];
    logic [NPW-1:0]      r_cfg_count[CHANNELS];
    logic [CHANNELS-1:0] r_cfg_mode;
    logic [WIDTH-1:0]    r_run_high [CHANNELS];
    logic [WIDTH-1:0]    r_run_low  [CHANNELS];
    logic [CHANNELS-1:0] r_run_mode;
    logic [CHANNELS-1:0] r_on_q;
    logic [CHANNELS-1:0] r_armed;
    logic [CHANNELS-1:0] w_trig;
    logic [CHANNELS-1:0] w_start;
    logic [CHANNELS-1:0] w_sig_nx;
    logic [CHANNELS-1:0] w_done_nx;

    // Zero-length fields behave as length 1, so the reload value saturates at 0.
    function automatic logic [WIDTH-1:0] dec_w(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - WIDTH'(1);
    endfunction

    function automatic logic [NPW-1:0] dec_n(input logic [NPW-1:0] v);
        return (v == '0) ? '0 : v - NPW'(1);
    endfunction

    // A level held high through reset must not start a run: a channel arms only
    // after it has sampled on[i] low at least once.
    assign w_trig = on & ~r_on_q & r_armed;

    always_comb begin
        w_sig_nx  = signal;
        w_done_nx = '0;
        w_start   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_rem_nx[i]   = r_rem[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_trig[i]) begin
                        w_start[i]    = 1'b1;
                        w_state_nx[i] = ST_HIGH;
                        w_cnt_nx[i]   = dec_w(r_cfg_high[i]);
                        w_rem_nx[i]   = dec_n(r_cfg_count[i]);
                        w_sig_nx[i]   = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (r_cnt[i] != '0) begin
                        w_cnt_nx[i] = r_cnt[i] - WIDTH'(1);
                    end else if (r_run_mode[i] ? on[i] : (r_rem[i] != '0)) begin
                        w_state_nx[i] = ST_LOW;
                        w_cnt_nx[i]   = dec_w(r_run_low[i]);
                        w_rem_nx[i]   = dec_n(r_rem[i]);
                        w_sig_nx[i]   = 1'b0;
                    end else begin
                        w_state_nx[i] = ST_IDLE;
                        w_sig_nx[i]   = 1'b0;
                        w_done_nx[i]  = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (r_cnt[i] != '0) begin
                        w_cnt_nx[i] = r_cnt[i] - WIDTH'(1);
                    end else begin
                        w_state_nx[i] = ST_HIGH;
                        w_cnt_nx[i]   = dec_w(r_run_high[i]);
                        w_sig_nx[i]   = 1'b1;
                    end
                end
                default: begin
                    w_state_nx[i] = ST_IDLE;
                    w_sig_nx[i]   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            signal     <= '0;
            busy       <= '0;
            done       <= '0;
            r_on_q     <= '0;
            r_armed    <= '0;
            r_cfg_mode <= '0;
            r_run_mode <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i]     <= ST_IDLE;
                r_cnt[i]       <= '0;
                r_rem[i]       <= '0;
                r_cfg_high[i]  <= WIDTH'(1);
                r_cfg_low[i]   <= WIDTH'(1);
                r_cfg_count[i] <= NPW'(1);
                r_run_high[i]  <= WIDTH'(1);
                r_run_low[i]   <= WIDTH'(1);
            end
        end else begin
            signal  <= w_sig_nx;
            done    <= w_done_nx;
            r_on_q  <= on;
            r_armed <= r_armed | ~on;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_rem[i]   <= w_rem_nx[i];
                busy[i]    <= (w_state_nx[i] != ST_IDLE);
                if (w_start[i]) begin
                    r_run_high[i] <= r_cfg_high[i];
                    r_run_low[i]  <= r_cfg_low[i];
                    r_run_mode[i] <= r_cfg_mode[i];
                end
                // Out-of-range channel indices match no channel and are dropped.
                if (cfg_we && (cfg_ch == CHW'(i))) begin
                    r_cfg_high[i]  <= cfg_high;
                    r_cfg_low[i]   <= cfg_low;
                    r_cfg_count[i] <= cfg_count;
                    r_cfg_mode[i]  <= cfg_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen (3 channels): directed tables, corner
// sequences and random traffic against a cycle-index reference model.
module tb_pulse_train_gen;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int NP = 4;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CH-1:0] on;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_high;
    logic [W-1:0]  cfg_low;
    logic [NP-1:0] cfg_count;
    logic          cfg_mode;
    logic [CH-1:0] signal;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;

    always #5 clock = ~clock;

    pulse_train_gen #(.CHANNELS(CH), .WIDTH(W), .NPW(NP), .CHW(CW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .on       (on),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_high (cfg_high),
        .cfg_low  (cfg_low),
        .cfg_count(cfg_count),
        .cfg_mode (cfg_mode),
        .signal   (signal),
        .busy     (busy),
        .done     (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is described by its cycle index t since the start edge.
    // Pulse period P = H+L; signal is high while (t mod P) < H.
    int            m_h [CH], m_l [CH], m_n [CH];
    bit            m_mode [CH];
    bit            m_act [CH], m_prev_low [CH], m_rmode [CH];
    int            m_t [CH], m_rh [CH], m_rl [CH], m_rn [CH];
    logic [CH-1:0] m_sig, m_busy, m_done;

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_h[i] = 1; m_l[i] = 1; m_n[i] = 1; m_mode[i] = 1'b0;
            m_act[i] = 1'b0; m_prev_low[i] = 1'b0; m_t[i] = 0;
        end
        m_sig = '0; m_busy = '0; m_done = '0;
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < CH; i++) begin
            automatic bit trig = on[i] && m_prev_low[i];
            automatic int p, total, ph;
            m_done[i] = 1'b0;
            if (!m_act[i]) begin
                if (trig) begin
                    m_act[i]   = 1'b1;
                    m_t[i]     = 0;
                    m_rh[i]    = (m_h[i] == 0) ? 1 : m_h[i];
                    m_rl[i]    = (m_l[i] == 0) ? 1 : m_l[i];
                    m_rn[i]    = (m_n[i] == 0) ? 1 : m_n[i];
                    m_rmode[i] = m_mode[i];
                    m_sig[i]   = 1'b1;
                    m_busy[i]  = 1'b1;
                end
            end else begin
                m_t[i]++;
                p     = m_rh[i] + m_rl[i];
                total = m_rn[i] * m_rh[i] + (m_rn[i] - 1) * m_rl[i];
                ph    = m_t[i] % p;
                if ((!m_rmode[i] && m_t[i] == total) ||
                    (m_rmode[i] && ph == m_rh[i] && !on[i])) begin
                    m_act[i]  = 1'b0;
                    m_sig[i]  = 1'b0;
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end else begin
                    m_sig[i] = (ph < m_rh[i]);
                end
            end
            m_prev_low[i] = !on[i];
        end
        if (cfg_we && int'(cfg_ch) < CH) begin
            m_h[int'(cfg_ch)]    = int'(cfg_high);
            m_l[int'(cfg_ch)]    = int'(cfg_low);
            m_n[int'(cfg_ch)]    = int'(cfg_count);
            m_mode[int'(cfg_ch)] = cfg_mode;
        end
    endfunction

    // One clock: model advances on the inputs seen at the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("model_signal", 32'(signal), 32'(m_sig));
        chk("model_busy",   32'(busy),   32'(m_busy));
        chk("model_done",   32'(done),   32'(m_done));
    endtask

    task automatic cfg_wr(input int ch, input int h, input int l, input int n, input bit mode);
        cfg_we    = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_high  = W'(h);
        cfg_low   = W'(l);
        cfg_count = NP'(n);
        cfg_mode  = mode;
        step();
        cfg_we    = 1'b0;
    endtask

    // Raises on[ch], runs until busy drops; 'live' toggles on and rewrites H=5 mid-run.
    task automatic measure(input int ch, input bit live, output int n_busy, output int n_rise);
        logic prev;
        int   k;
        n_busy = 0; n_rise = 0; prev = 1'b0; k = 0;
        on[ch] = 1'b1;
        step();
        while (busy[ch] && k < 200) begin
            n_busy++;
            if (signal[ch] && !prev) n_rise++;
            prev = signal[ch];
            k++;
            if (live) begin
                if (k == 1) on[ch] = 1'b0;
                if (k == 2) begin
                    on[ch] = 1'b1;
                    cfg_we = 1'b1; cfg_ch = CW'(ch);
                    cfg_high = W'(5); cfg_low = W'(1); cfg_count = NP'(2); cfg_mode = 1'b0;
                end
                if (k == 3) cfg_we = 1'b0;
            end
            step();
        end
        chk("run_bounded", 32'(k < 200), 32'd1);
        chk("run_done", 32'(done[ch]), 32'd1);
    endtask

    typedef struct {
        logic [CH-1:0] on_v;
        logic [CH-1:0] e_sig;
        logic [CH-1:0] e_busy;
        logic [CH-1:0] e_done;
    } vec_t;

    vec_t tbl[$];

    task automatic run_table(input string name);
        for (int k = 0; k < tbl.size(); k++) begin
            on = tbl[k].on_v;
            step();
            chk({name, "_signal"}, 32'(signal), 32'(tbl[k].e_sig));
            chk({name, "_busy"},   32'(busy),   32'(tbl[k].e_busy));
            chk({name, "_done"},   32'(done),   32'(tbl[k].e_done));
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] p_sig, p_busy, p_done;
        logic [9:0]  c_sig, c_busy, c_done;
        int nb, nr, nb0, nb1, nb2, nd0, nd1, nd2;

        reset_n = 1'b0; on = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_high = '0; cfg_low = '0; cfg_count = '0; cfg_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_signal", 32'(signal), 32'd0);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        reset_n = 1'b1;
        repeat (2) step();

        // Counted burst: ch0 H=3 L=2 N=3.
        cfg_wr(0, 3, 2, 3, 1'b0);
        p_sig  = 15'b001110011100111;
        p_busy = 15'b001111111111111;
        p_done = 15'b010000000000000;
        for (int k = 0; k < 15; k++)
            tbl.push_back('{3'b001, {2'b00, p_sig[k]}, {2'b00, p_busy[k]}, {2'b00, p_done[k]}});
        run_table("burst");
        on = '0;
        step();

        // Zero fields: ch1 H=0 L=0 N=0 gives one 1-cycle pulse.
        cfg_wr(1, 0, 0, 0, 1'b0);
        on = 3'b010;
        step();
        chk("zero_signal_on", 32'(signal[1]), 32'd1);
        chk("zero_busy_on",   32'(busy[1]),   32'd1);
        step();
        chk("zero_signal_off", 32'(signal[1]), 32'd0);
        chk("zero_done",       32'(done[1]),   32'd1);
        chk("zero_busy_off",   32'(busy[1]),   32'd0);
        on = '0;
        step();

        // Continuous: ch2 H=2 L=1 mode 1, on high for 7 sampled edges.
        cfg_wr(2, 2, 1, 0, 1'b1);
        c_sig  = 10'b0011011011;
        c_busy = 10'b0011111111;
        c_done = 10'b0100000000;
        for (int k = 0; k < 10; k++)
            tbl.push_back('{(k < 7) ? 3'b100 : 3'b000, {c_sig[k], 2'b00}, {c_busy[k], 2'b00}, {c_done[k], 2'b00}});
        run_table("cont");

        // Retrigger and live config on ch0: H=2 L=1 N=2 run stays 5 cycles, next run uses H=5.
        cfg_wr(0, 2, 1, 2, 1'b0);
        measure(0, 1'b1, nb, nr);
        chk("retrig_busy_len", 32'(nb), 32'd5);
        chk("retrig_pulses",   32'(nr), 32'd2);
        repeat (2) step();
        chk("retrig_not_queued", 32'(busy[0]), 32'd0);
        on = '0;
        step();
        measure(0, 1'b0, nb, nr);
        chk("live_cfg_busy_len", 32'(nb), 32'd11);
        chk("live_cfg_pulses",   32'(nr), 32'd2);
        on = '0;
        step();

        // Concurrency with an out-of-range write to cfg_ch=3.
        cfg_wr(0, 1, 1, 2, 1'b0);
        cfg_wr(1, 2, 1, 1, 1'b0);
        cfg_wr(2, 4, 2, 2, 1'b0);
        cfg_wr(3, 7, 7, 7, 1'b1);
        on = 3'b111;
        nb0 = 0; nb1 = 0; nb2 = 0; nd0 = 0; nd1 = 0; nd2 = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            nb0 += int'(busy[0]); nb1 += int'(busy[1]); nb2 += int'(busy[2]);
            nd0 += int'(done[0]); nd1 += int'(done[1]); nd2 += int'(done[2]);
        end
        chk("conc_busy0", 32'(nb0), 32'd3);
        chk("conc_busy1", 32'(nb1), 32'd2);
        chk("conc_busy2", 32'(nb2), 32'd10);
        chk("conc_done_count", 32'(nd0 + nd1 + nd2), 32'd3);
        on = '0;
        step();

        // Reset during a HIGH phase; on[1] held high across release.
        cfg_wr(1, 6, 1, 1, 1'b0);
        on = 3'b010;
        step();
        step();
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_signal", 32'(signal), 32'd0);
        chk("midrst_busy",   32'(busy),   32'd0);
        chk("midrst_done",   32'(done),   32'd0);
        model_reset();
        #2 reset_n = 1'b1;
        repeat (4) step();
        chk("midrst_no_restart", 32'(busy[1]), 32'd0);
        on = '0;
        step();
        on = 3'b010;
        step();
        chk("midrst_fresh_start", 32'(signal[1]), 32'd1);
        step();
        chk("midrst_default_cfg_done", 32'(done[1]), 32'd1);
        on = '0;
        step();

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(3) == 0) on[$urandom_range(CH - 1)] ^= 1'b1;
            if ($urandom_range(7) == 0) begin
                cfg_we    = 1'b1;
                cfg_ch    = CW'($urandom_range(3));
                cfg_high  = W'($urandom_range(3));
                cfg_low   = W'($urandom_range(3));
                cfg_count = NP'($urandom_range(3));
                cfg_mode  = 1'($urandom_range(1));
            end else begin
                cfg_we = 1'b0;
            end
            step();
        end
        cfg_we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
